// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit: single-cycle ALU ops, 16-cycle shift-add multiply,
// and a one-cycle register-file write-back strobe.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [2:0]  dest,
  input  logic        wb_en,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        zero,
  output logic        err,
  output logic        RegWrite,
  output logic [2:0]  write_reg,
  output logic [15:0] write_data
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [3:0]  op_q, op_d, cnt_q, cnt_d;
  logic [2:0]  dest_q, dest_d, write_reg_q, write_reg_d;
  logic        wben_q, wben_d, err_q, err_d, done_q, done_d, reg_write_q, reg_write_d;
  logic [15:0] result_q, result_d, write_data_q, write_data_d;

  logic [15:0] alu_res, acc_nxt;
  logic        alu_ill;
  logic [3:0]  sh;

  assign sh = b_q[3:0];

  always_comb begin
    alu_res = 16'd0;
    alu_ill = 1'b0;
    case (op_q)
      4'd0:    alu_res = a_q + b_q;
      4'd1:    alu_res = a_q - b_q;
      4'd2:    alu_res = a_q & b_q;
      4'd3:    alu_res = a_q | b_q;
      4'd4:    alu_res = a_q ^ b_q;
      4'd5:    alu_res = ~a_q;
      4'd6:    alu_res = {15'd0, $signed(a_q) < $signed(b_q)};
      4'd7:    alu_res = a_q << sh;
      4'd8:    alu_res = a_q >> sh;
      4'd9:    alu_res = $signed(a_q) >>> sh;
      default: alu_ill = 1'b1;  // MUL never reaches EXEC, so 10 lands here harmlessly
    endcase
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    dest_d       = dest_q;
    wben_d       = wben_q;
    err_d        = err_q;
    done_d       = 1'b0;
    reg_write_d  = 1'b0;
    result_d     = result_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    acc_nxt      = acc_q + (b_q[0] ? a_q : 16'd0);
    case (state_q)
      IDLE: if (start) begin
        a_d     = data1;
        b_d     = data2;
        op_d    = op;
        dest_d  = dest;
        wben_d  = wb_en;
        acc_d   = 16'd0;
        cnt_d   = 4'd0;
        state_d = (op == 4'd10) ? MUL : EXEC;
      end
      EXEC: begin
        result_d     = alu_res;
        err_d        = alu_ill;
        write_reg_d  = dest_q;
        write_data_d = alu_res;
        done_d       = 1'b1;
        reg_write_d  = wben_q & ~alu_ill;
        state_d      = WB;
      end
      MUL: begin
        // multiplicand walks left, multiplier walks right: bit cnt_q of B is in b_q[0]
        acc_d = acc_nxt;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          result_d     = acc_nxt;
          err_d        = 1'b0;
          write_reg_d  = dest_q;
          write_data_d = acc_nxt;
          done_d       = 1'b1;
          reg_write_d  = wben_q;
          state_d      = WB;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= 16'd0;
      b_q          <= 16'd0;
      acc_q        <= 16'd0;
      op_q         <= 4'd0;
      cnt_q        <= 4'd0;
      dest_q       <= 3'd0;
      wben_q       <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      reg_write_q  <= 1'b0;
      result_q     <= 16'd0;
      write_reg_q  <= 3'd0;
      write_data_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      dest_q       <= dest_d;
      wben_q       <= wben_d;
      err_q        <= err_d;
      done_q       <= done_d;
      reg_write_q  <= reg_write_d;
      result_q     <= result_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign result     = result_q;
  assign zero       = (result_q == 16'd0);
  assign err        = err_q;
  assign RegWrite   = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized + directed bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk, rst, start, wb_en;
  logic [3:0]  op;
  logic [2:0]  dest;
  logic [15:0] data1, data2;
  logic        busy, done, zero, err, RegWrite;
  logic [15:0] result, write_data;
  logic [2:0]  write_reg;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dest(dest), .wb_en(wb_en),
    .data1(data1), .data2(data2), .busy(busy), .done(done), .result(result),
    .zero(zero), .err(err), .RegWrite(RegWrite), .write_reg(write_reg),
    .write_data(write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {err, result} from plain integer arithmetic.
  function automatic logic [16:0] model(input logic [3:0] o, input logic [15:0] d1, input logic [15:0] d2);
    longint a, b, sa, sb, r;
    int sh;
    a  = d1;
    b  = d2;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    sh = int'(d2 % 16);
    case (o)
      4'd0:  r = a + b;
      4'd1:  r = a - b + 65536;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = 65535 - a;
      4'd6:  r = (sa < sb) ? 1 : 0;
      4'd7:  r = a * (longint'(1) << sh);
      4'd8:  r = a / (longint'(1) << sh);
      4'd9:  r = sa >>> sh;
      4'd10: r = a * b;
      default: return {1'b1, 16'd0};
    endcase
    return {1'b0, 16'(r & 65535)};
  endfunction

  // Entered and left at a negedge with the unit idle, so calls chain back-to-back.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] d1,
                        input logic [15:0] d2, input logic [2:0] ds, input logic we,
                        input bit inject);
    logic [16:0] m;
    int lat, bcy, exp_lat;
    m       = model(o, d1, d2);
    exp_lat = (o == 4'd10) ? 17 : 2;
    op = o; data1 = d1; data2 = d2; dest = ds; wb_en = we; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    data1 = 16'($urandom); data2 = 16'($urandom);
    op = 4'($urandom); dest = 3'($urandom); wb_en = 1'($urandom);
    lat = 0; bcy = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 2) start = 1'b0;
      if (busy) bcy++;
      if (done) begin lat = c; break; end
      if (inject && c == 1) begin start = 1'b1; op = 4'd0; end
    end
    if (lat == 0) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_lat"},    lat, exp_lat);
    chk({tag, "_busy"},   bcy, exp_lat);
    chk({tag, "_res"},    result, m[15:0]);
    chk({tag, "_zero"},   zero, (m[15:0] == 16'd0));
    chk({tag, "_err"},    err, m[16]);
    chk({tag, "_rw"},     RegWrite, we & ~m[16]);
    chk({tag, "_wreg"},   write_reg, ds);
    chk({tag, "_wdata"},  write_data, m[15:0]);
    @(negedge clk);
    chk({tag, "_idle"},   {busy, done, RegWrite}, 3'b000);
    chk({tag, "_hold"},   write_data, m[15:0]);
  endtask

  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; op = 4'd0; dest = 3'd0; wb_en = 1'b0;
    data1 = 16'd0; data2 = 16'd0;
    #1;
    chk("rst_state", {busy, done, RegWrite, err, zero}, 5'b00001);
    chk("rst_outs",  {result, write_reg, write_data}, 35'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_ovf", 4'd0,  16'h7FFF, 16'h0001, 3'd3, 1'b1, 0);
    run_op("slt",     4'd6,  16'hFFFF, 16'h0001, 3'd1, 1'b1, 0);
    run_op("sub0",    4'd1,  16'h0005, 16'h0005, 3'd2, 1'b1, 0);
    run_op("sra",     4'd9,  16'h8000, 16'h0004, 3'd4, 1'b0, 0);
    run_op("mul",     4'd10, 16'h0123, 16'h0045, 3'd6, 1'b1, 1);
    run_op("ill",     4'd12, 16'h1234, 16'h5678, 3'd7, 1'b1, 0);
    run_op("add23",   4'd0,  16'h0002, 16'h0003, 3'd5, 1'b1, 1);
    run_op("b2b",     4'd4,  16'hA5A5, 16'h0FF0, 3'd1, 1'b1, 0);

    for (int i = 0; i < 40; i++)
      run_op("rnd", 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
             3'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));

    // abort a multiply in flight; outputs must clear with no clock edge
    run_op("pre_rst", 4'd0, 16'h1111, 16'h2222, 3'd5, 1'b1, 0);
    op = 4'd10; data1 = 16'h00FF; data2 = 16'h00FF; dest = 3'd2; wb_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ctl",  {busy, done, RegWrite, err}, 4'b0000);
    chk("arst_res",  result, 16'd0);
    chk("arst_wb",   {write_reg, write_data}, 19'd0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done || RegWrite || busy) dn++;
    end
    chk("arst_nodone", dn, 0);
    run_op("post_rst", 4'd0, 16'h0002, 16'h0003, 3'd3, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
